// File: rtl/uart_tx_msg_arbiter.sv
// uart_tx_msg_arbiter
// Lets NUM_SRC byte-stream sources share one UART tx FIFO write port.
// Arbitration is round-robin per message: a granted source keeps the port
// until its last byte is written. Each message can be framed with a header
// byte {HDR_TAG, source id} and a trailer byte (payload byte count mod 256).
// Port outputs are decoded combinationally from the registered state, so the
// FIFO write strobe can follow tx_fifo_full within the same cycle.

module uart_tx_msg_arbiter #(
    parameter int         NUM_SRC = 4,
    parameter bit         HDR_EN  = 1'b1,
    parameter bit         TRL_EN  = 1'b1,
    parameter logic [3:0] HDR_TAG = 4'hA
) (
    input  logic                 clk_tx,
    input  logic                 rst_clk_tx_n,
    input  logic [NUM_SRC-1:0]   src_valid,
    input  logic [8*NUM_SRC-1:0] src_data,
    input  logic [NUM_SRC-1:0]   src_last,
    output logic [NUM_SRC-1:0]   src_ready,
    output logic [7:0]           tx_din,
    output logic                 write_en,
    input  logic                 tx_fifo_full,
    output logic                 busy,
    output logic [3:0]           cur_src
);

    localparam int GW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        TRL
    } state_t;

    state_t        state;
    logic [GW-1:0] gnt;
    logic [GW-1:0] rr_ptr;
    logic [7:0]    cnt;

    logic [GW-1:0] pick;
    logic          pick_found;
    logic [7:0]    gnt_data;
    logic          gnt_valid;
    logic          gnt_last;
    logic [3:0]    gnt_id;

    assign gnt_id  = 4'(gnt);
    assign busy    = (state != IDLE);
    assign cur_src = busy ? gnt_id : 4'd0;

    // Route the granted source's valid/last/data lanes to single signals.
    // NOTE: every signal written in an always_comb gets a default first, so no
    // path can leave it unassigned and infer a latch.
    always_comb begin
        gnt_data  = '0;
        gnt_valid = 1'b0;
        gnt_last  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (gnt == GW'(i)) begin
                gnt_data  = src_data[8*i +: 8];
                gnt_valid = src_valid[i];
                gnt_last  = src_last[i];
            end
        end
    end

    // Round-robin pick: first requester above rr_ptr, then wrap to 0..rr_ptr.
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!pick_found && src_valid[i] && (GW'(i) > rr_ptr)) begin
                pick       = GW'(i);
                pick_found = 1'b1;
            end
        end
        for (int i = 0; i < NUM_SRC; i++) begin
            if (!pick_found && src_valid[i] && (GW'(i) <= rr_ptr)) begin
                pick       = GW'(i);
                pick_found = 1'b1;
            end
        end
    end

    // FIFO write port and source handshake, decoded from the current state.
    always_comb begin
        src_ready = '0;
        write_en  = 1'b0;
        tx_din    = 8'h00;
        case (state)
            HDR: begin
                tx_din   = {HDR_TAG, gnt_id};
                write_en = ~tx_fifo_full;
            end
            DATA: begin
                tx_din   = gnt_data;
                write_en = gnt_valid & ~tx_fifo_full;
                for (int i = 0; i < NUM_SRC; i++) begin
                    src_ready[i] = (gnt == GW'(i)) & ~tx_fifo_full;
                end
            end
            TRL: begin
                tx_din   = cnt;
                write_en = ~tx_fifo_full;
            end
            default: begin
            end
        endcase
    end

    // Message sequencer: grant, header, payload, trailer, back to idle.
    // NOTE: clocked state uses non-blocking assignments so every register
    // updates from the values present before the edge.
    always_ff @(posedge clk_tx or negedge rst_clk_tx_n) begin
        if (!rst_clk_tx_n) begin
            state  <= IDLE;
            gnt    <= '0;
            rr_ptr <= GW'(NUM_SRC - 1);
            cnt    <= 8'h00;
        end else begin
            case (state)
                IDLE: begin
                    if (|src_valid) begin
                        gnt <= pick;
                        cnt <= 8'h00;
                        if (HDR_EN) state <= HDR;
                        else        state <= DATA;
                    end
                end
                HDR: begin
                    if (!tx_fifo_full) state <= DATA;
                end
                DATA: begin
                    if (gnt_valid && !tx_fifo_full) begin
                        cnt <= cnt + 8'd1;
                        if (gnt_last) begin
                            rr_ptr <= gnt;
                            if (TRL_EN) state <= TRL;
                            else        state <= IDLE;
                        end
                    end
                end
                TRL: begin
                    if (!tx_fifo_full) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_msg_arbiter.sv
// Testbench for uart_tx_msg_arbiter.
// Sources hold pre-loaded message queues; a reference model derives the
// expected FIFO byte stream from round-robin order over pending messages,
// and a negedge monitor pops and compares every FIFO write. A second
// instance without framing is exercised with a short directed sequence.

module tb_uart_tx_msg_arbiter;

    localparam int N = 4;

    logic           clk_tx = 1'b0;
    logic           rst_clk_tx_n = 1'b0;
    logic [N-1:0]   src_valid;
    logic [8*N-1:0] src_data;
    logic [N-1:0]   src_last;
    logic [N-1:0]   src_ready;
    logic [7:0]     tx_din;
    logic           write_en;
    logic           tx_fifo_full;
    logic           busy;
    logic [3:0]     cur_src;

    logic [N-1:0]   nf_src_valid;
    logic [8*N-1:0] nf_src_data;
    logic [N-1:0]   nf_src_last;
    logic [N-1:0]   nf_src_ready;
    logic [7:0]     nf_tx_din;
    logic           nf_write_en;
    logic           nf_full;
    logic           nf_busy;
    logic [3:0]     nf_cur_src;

    always #5 clk_tx = ~clk_tx;

    uart_tx_msg_arbiter #(.NUM_SRC(N), .HDR_EN(1'b1), .TRL_EN(1'b1), .HDR_TAG(4'hA)) dut (
        .clk_tx(clk_tx), .rst_clk_tx_n(rst_clk_tx_n),
        .src_valid(src_valid), .src_data(src_data), .src_last(src_last),
        .src_ready(src_ready), .tx_din(tx_din), .write_en(write_en),
        .tx_fifo_full(tx_fifo_full), .busy(busy), .cur_src(cur_src)
    );

    uart_tx_msg_arbiter #(.NUM_SRC(N), .HDR_EN(1'b0), .TRL_EN(1'b0), .HDR_TAG(4'hA)) dut_nf (
        .clk_tx(clk_tx), .rst_clk_tx_n(rst_clk_tx_n),
        .src_valid(nf_src_valid), .src_data(nf_src_data), .src_last(nf_src_last),
        .src_ready(nf_src_ready), .tx_din(nf_tx_din), .write_en(nf_write_en),
        .tx_fifo_full(nf_full), .busy(nf_busy), .cur_src(nf_cur_src)
    );

    typedef struct {
        logic [7:0] data;
        int         src;
        bit         trl;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] nf_exp[$];
    logic [7:0] msg_q[N][$];
    int         len_q[N][$];
    int         sent[N];
    bit         acc[N];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int wr_count = 0;
    int nf_wr = 0;
    int full_mode = 0;
    bit drv_en = 1'b0;
    bit bubbles = 1'b0;
    bit pend_idle = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    always @(posedge clk_tx) cyc <= cyc + 1;

    // Source drivers: sample handshakes mid-cycle, advance after the edge.
    initial begin
        forever begin
            @(negedge clk_tx);
            for (int i = 0; i < N; i++) acc[i] = src_valid[i] & src_ready[i];
            @(posedge clk_tx);
            #1;
            if (drv_en) begin
                for (int i = 0; i < N; i++) begin
                    if (acc[i] && msg_q[i].size() > 0) begin
                        void'(msg_q[i].pop_front());
                        sent[i]++;
                        if (sent[i] == len_q[i][0]) begin
                            void'(len_q[i].pop_front());
                            sent[i] = 0;
                        end
                    end
                    if (msg_q[i].size() > 0 &&
                        (sent[i] == 0 || !bubbles || $urandom_range(0, 3) != 0)) begin
                        src_valid[i]       = 1'b1;
                        src_data[8*i +: 8] = msg_q[i][0];
                        src_last[i]        = (len_q[i][0] - sent[i] == 1);
                    end else begin
                        src_valid[i]       = 1'b0;
                        src_data[8*i +: 8] = 8'($urandom);
                        src_last[i]        = 1'($urandom);
                    end
                end
            end
        end
    end

    // FIFO full pattern: never, random, or 5-cycle bursts.
    always @(posedge clk_tx) begin
        #1;
        case (full_mode)
            1:       tx_fifo_full = ($urandom_range(0, 3) == 0);
            2:       tx_fifo_full = ((cyc % 13) < 5);
            default: tx_fifo_full = 1'b0;
        endcase
    end

    // Monitor for the framed instance.
    always @(negedge clk_tx) begin : mon
        exp_t e;
        bit   has;
        if (rst_clk_tx_n) begin
            if (pend_idle) begin
                check("idle_after_trailer", {busy, cur_src}, 0);
                pend_idle = 1'b0;
            end
            if (tx_fifo_full) check("stall_no_write", {write_en, src_ready}, 0);
            for (int i = 0; i < N; i++) begin
                if (src_valid[i] && src_ready[i])
                    check("xfer_strobe", {write_en, cur_src}, {1'b1, 4'(i)});
            end
            if (write_en) begin
                wr_count++;
                has = (exp_q.size() > 0);
                check("write_expected", has, 1);
                if (has) begin
                    e = exp_q.pop_front();
                    check("tx_byte", tx_din, e.data);
                    check("tx_src", cur_src, e.src);
                    if (e.trl) pend_idle = 1'b1;
                end
            end
        end
    end

    // Monitor for the unframed instance.
    always @(negedge clk_tx) begin : nf_mon
        logic [7:0] b;
        bit         has;
        if (rst_clk_tx_n && nf_write_en) begin
            nf_wr++;
            has = (nf_exp.size() > 0);
            check("nf_write_expected", has, 1);
            if (has) begin
                b = nf_exp.pop_front();
                check("nf_tx_byte", nf_tx_din, b);
            end
        end
    end

    // Reference model: walk pending messages in round-robin order, starting
    // after source N-1, and list the bytes the FIFO must receive.
    task automatic build_expected();
        int   li[N];
        int   bo[N];
        int   ptr;
        int   left;
        int   len;
        bit   found;
        exp_t e;
        left = 0;
        for (int i = 0; i < N; i++) begin
            li[i] = 0;
            bo[i] = 0;
            left += len_q[i].size();
        end
        ptr = N - 1;
        while (left > 0) begin
            found = 1'b0;
            for (int off = 1; off <= N; off++) begin
                int k;
                k = (ptr + off) % N;
                if (!found && li[k] < len_q[k].size()) begin
                    found = 1'b1;
                    len = len_q[k][li[k]];
                    e.src = k;
                    e.trl = 1'b0;
                    e.data = 8'hA0 + 8'(k);
                    exp_q.push_back(e);
                    for (int j = 0; j < len; j++) begin
                        e.data = msg_q[k][bo[k] + j];
                        exp_q.push_back(e);
                    end
                    e.data = 8'(len % 256);
                    e.trl = 1'b1;
                    exp_q.push_back(e);
                    bo[k] += len;
                    li[k]++;
                    ptr = k;
                    left--;
                end
            end
        end
    endtask

    function automatic int pending_bytes();
        int s = 0;
        for (int i = 0; i < N; i++) s += msg_q[i].size();
        return s;
    endfunction

    task automatic clear_all();
        drv_en = 1'b0;
        for (int i = 0; i < N; i++) begin
            msg_q[i].delete();
            len_q[i].delete();
            sent[i] = 0;
        end
        src_valid = '0;
        src_last  = '0;
        src_data  = '0;
        exp_q.delete();
        pend_idle = 1'b0;
    endtask

    task automatic add_msg(input int s, input int len);
        len_q[s].push_back(len);
        for (int j = 0; j < len; j++) msg_q[s].push_back(8'($urandom));
    endtask

    task automatic start_phase(input int fm, input bit bub);
        rst_clk_tx_n = 1'b0;
        build_expected();
        full_mode = fm;
        bubbles = bub;
        drv_en = 1'b1;
        repeat (2) @(posedge clk_tx);
        @(negedge clk_tx);
        rst_clk_tx_n = 1'b1;
    endtask

    task automatic run_phase(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() > 0 || pending_bytes() > 0) && n < budget) begin
            @(negedge clk_tx);
            n++;
        end
        if (n >= budget) check({tag, "_timeout"}, exp_q.size(), 0);
        repeat (4) @(negedge clk_tx);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    task automatic nf_send(input int s, input int len, input logic [7:0] base);
        int n;
        for (int j = 0; j < len; j++) begin
            @(posedge clk_tx);
            #1;
            nf_src_valid[s]       = 1'b1;
            nf_src_data[8*s +: 8] = base + 8'(j);
            nf_src_last[s]        = (j == len - 1);
            n = 0;
            do begin
                @(negedge clk_tx);
                n++;
            end while (!nf_src_ready[s] && n < 50);
            if (n >= 50) check("nf_ready_timeout", nf_src_ready[s], 1);
        end
        @(posedge clk_tx);
        #1;
        nf_src_valid = '0;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int w0;
        nf_src_valid = '0;
        nf_src_data  = '0;
        nf_src_last  = '0;
        nf_full      = 1'b0;
        tx_fifo_full = 1'b0;
        clear_all();

        // Reset with every source requesting.
        rst_clk_tx_n = 1'b0;
        src_valid = '1;
        src_last  = '1;
        src_data  = 32'hDEADBEEF;
        repeat (3) @(negedge clk_tx);
        check("rst_write_en", write_en, 0);
        check("rst_src_ready", src_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_tx_din", tx_din, 0);
        check("rst_cur_src", cur_src, 0);

        // Single message from source 2: A2 11 22 33 03.
        clear_all();
        len_q[2].push_back(3);
        msg_q[2].push_back(8'h11);
        msg_q[2].push_back(8'h22);
        msg_q[2].push_back(8'h33);
        start_phase(0, 1'b0);
        run_phase("single", 100);

        // Round robin: every source sends two 1-byte messages.
        rst_clk_tx_n = 1'b0;
        clear_all();
        for (int s = 0; s < N; s++) begin
            add_msg(s, 1);
            add_msg(s, 1);
        end
        start_phase(0, 1'b0);
        run_phase("round_robin", 200);

        // Backpressure in 5-cycle bursts, with payload bubbles.
        rst_clk_tx_n = 1'b0;
        clear_all();
        for (int s = 0; s < N; s++)
            for (int m = 0; m < 3; m++) add_msg(s, $urandom_range(1, 12));
        start_phase(2, 1'b1);
        run_phase("burst_full", 3000);

        // Random backpressure and bubbles.
        rst_clk_tx_n = 1'b0;
        clear_all();
        for (int s = 0; s < N; s++)
            for (int m = 0; m < 3; m++) add_msg(s, $urandom_range(1, 20));
        start_phase(1, 1'b1);
        run_phase("rand_full", 4000);

        // Trailer wrap: 256 bytes -> 0x00, 257 bytes -> 0x01.
        rst_clk_tx_n = 1'b0;
        clear_all();
        add_msg(1, 256);
        add_msg(1, 257);
        start_phase(1, 1'b0);
        run_phase("wrap", 3000);

        // Unframed build: payload bytes only.
        nf_exp.delete();
        for (int j = 0; j < 4; j++) nf_exp.push_back(8'h31 + 8'(j));
        for (int j = 0; j < 2; j++) nf_exp.push_back(8'h01 + 8'(j));
        nf_wr = 0;
        nf_send(3, 4, 8'h31);
        nf_send(0, 2, 8'h01);
        repeat (3) @(negedge clk_tx);
        check("nf_writes", nf_wr, 6);
        check("nf_drained", nf_exp.size(), 0);

        // Asynchronous reset in the middle of a payload.
        rst_clk_tx_n = 1'b0;
        clear_all();
        add_msg(2, 30);
        start_phase(0, 1'b0);
        w0 = wr_count;
        n = 0;
        while (wr_count < w0 + 6 && n < 200) begin
            @(negedge clk_tx);
            n++;
        end
        check("midmsg_reached", busy, 1);
        @(posedge clk_tx);
        #3;
        rst_clk_tx_n = 1'b0;
        #1;
        check("async_rst_write_en", write_en, 0);
        check("async_rst_src_ready", src_ready, 0);
        check("async_rst_busy", busy, 0);
        check("async_rst_tx_din", tx_din, 0);
        clear_all();
        for (int s = 0; s < N; s++) add_msg(s, 2);
        start_phase(0, 1'b0);
        run_phase("after_reset", 200);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
